alu_sr_seq: RTL and testbench

- Multi-cycle right shifter for the ALU datapath; the right-shift counterpart to the 16-bit left-shift unit.
- Accepts an operand, a shift amount and a mode (logical or arithmetic).
- Shifts iteratively: coarse 16-bit steps, then 1-bit steps.
- Returns the result with a start/busy/done handshake, so the shift amount can be full range without a wide combinational barrel.

---
 rtl/alu_sr_seq.sv | 109 ++++++++++
 tb/tb_alu_sr_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_sr_seq.sv
// alu_sr_seq: multi-cycle right shifter (logical/arithmetic).
// A start request captures operand, amount and mode. The shift then runs
// in 16-bit coarse steps followed by 1-bit fine steps. The result is
// published on Z together with a one-cycle done pulse.
module alu_sr_seq #(
  parameter int N       = 32,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [N-1:0]       A,
  input  logic [SHAMT_W-1:0] AMT,
  input  logic               ARITH,
  output logic [N-1:0]       Z,
  output logic               busy,
  output logic               done
);

  // The remaining counter must be able to hold N itself (saturated amount).
  localparam int REM_W = $clog2(N + 1);
  // Wide enough to compare the amount port against N without truncation.
  localparam int CMP_W = (SHAMT_W > 32) ? SHAMT_W : 32;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [N-1:0]     sreg;
  logic [REM_W-1:0] rem;
  logic             mode;
  logic             fill;

  // Amounts at or beyond the datapath width behave exactly like a shift by N.
  function automatic logic [REM_W-1:0] clamp_amt(input logic [SHAMT_W-1:0] amt);
    logic [CMP_W-1:0] amt_ext;
    amt_ext = CMP_W'(amt);
    if (amt_ext >= CMP_W'(N)) begin
      return REM_W'(N);
    end
    return REM_W'(amt);
  endfunction

  // One shift step: the fill bit is prepended and an arithmetic shift on the
  // widened value replicates it into the vacated positions. This also works
  // for N == 16, where a coarse step empties the whole word.
  function automatic logic [N-1:0] shift_step(input logic [N-1:0] val,
                                              input logic         fbit,
                                              input logic         coarse);
    logic signed [N:0] ext;
    ext = {fbit, val};
    if (coarse) begin
      ext = ext >>> 16;
    end else begin
      ext = ext >>> 1;
    end
    return ext[N-1:0];
  endfunction

  // Sign fill keeps the MSB unchanged, so reading it every step is the same
  // as using the sign captured at start.
  assign fill = mode & sreg[N-1];

  // Control FSM plus shift datapath; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
      Z     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sreg  <= '0;
      rem   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sreg  <= A;
            mode  <= ARITH;
            rem   <= clamp_amt(AMT);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem == '0) begin
            Z     <= sreg;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (rem >= REM_W'(16)) begin
            sreg <= shift_step(sreg, fill, 1'b1);
            rem  <= rem - REM_W'(16);
          end else begin
            sreg <= shift_step(sreg, fill, 1'b0);
            rem  <= rem - REM_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sr_seq.sv
// Directed bench for alu_sr_seq (N=32): table of shift vectors with
// hand-computed results and latencies, plus handshake and reset sequences.
module tb_alu_sr_seq;

  logic        clk;
  logic        rstb;
  logic        start;
  logic [31:0] A;
  logic [5:0]  AMT;
  logic        ARITH;
  logic [31:0] Z;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic [31:0] prev_z;

  alu_sr_seq #(.N(32), .SHAMT_W(6)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .start (start),
    .A     (A),
    .AMT   (AMT),
    .ARITH (ARITH),
    .Z     (Z),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [5:0]  amt;
    logic        arith;
    logic [31:0] z;
    int          edges;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request; now=1 means drive immediately (e.g. in the done cycle).
  task automatic launch(input logic [31:0] a, input logic [5:0] amt,
                        input logic arith, input bit now);
    if (!now) @(negedge clk);
    A = a; AMT = amt; ARITH = arith; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs after capture; the result must not depend on them.
    A = ~a; AMT = amt ^ 6'h2A; ARITH = ~arith;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_done", {31'd0, done}, 32'd0);
  endtask

  // Wait for done, counting edges after the accepting edge.
  // glitch>0 pulses start with junk operands just before that edge.
  task automatic finish(input logic [31:0] expz, input int exp_edges,
                        input int glitch, input string name);
    int n;
    bit hold_ok;
    n = 0;
    hold_ok = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      if (glitch != 0 && e == glitch) begin
        start = 1'b1; A = 32'hFFFF_FFFF; AMT = 6'd1; ARITH = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        n = e;
        break;
      end
      if (busy !== 1'b1 || Z !== prev_z) hold_ok = 1'b0;
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done within 80 edges", name);
    end else begin
      chk({name, "_edges"}, 32'(n), 32'(exp_edges));
      chk({name, "_z"}, Z, expz);
      chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({name, "_hold"}, {31'd0, hold_ok}, 32'd1);
    end
    prev_z = expz;
  endtask

  initial begin
    vecs[0]  = '{32'h1234_5678, 6'd4,  1'b0, 32'h0123_4567, 5};
    vecs[1]  = '{32'h8000_0000, 6'd17, 1'b1, 32'hFFFF_C000, 3};
    vecs[2]  = '{32'h8000_0000, 6'd17, 1'b0, 32'h0000_4000, 3};
    vecs[3]  = '{32'hDEAD_BEEF, 6'd0,  1'b1, 32'hDEAD_BEEF, 1};
    vecs[4]  = '{32'h8000_0001, 6'd40, 1'b1, 32'hFFFF_FFFF, 3};
    vecs[5]  = '{32'h8000_0001, 6'd40, 1'b0, 32'h0000_0000, 3};
    vecs[6]  = '{32'hF000_0000, 6'd31, 1'b1, 32'hFFFF_FFFF, 17};
    vecs[7]  = '{32'h7FFF_FFFF, 6'd32, 1'b1, 32'h0000_0000, 3};
    vecs[8]  = '{32'h8000_0000, 6'd16, 1'b1, 32'hFFFF_8000, 2};
    vecs[9]  = '{32'h8000_0000, 6'd15, 1'b0, 32'h0001_0000, 16};
    vecs[10] = '{32'hFFFF_FFFF, 6'd63, 1'b0, 32'h0000_0000, 3};
    vecs[11] = '{32'h8000_1234, 6'd1,  1'b1, 32'hC000_091A, 2};

    rstb = 1'b0; start = 1'b0; A = '0; AMT = '0; ARITH = 1'b0;
    prev_z = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_z", Z, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].a, vecs[i].amt, vecs[i].arith, 1'b0);
      finish(vecs[i].z, vecs[i].edges, 0, $sformatf("vec%0d", i));
    end

    // start pulsed while busy with other operands is ignored
    launch(32'h1234_5678, 6'd8, 1'b0, 1'b0);
    finish(32'h0012_3456, 9, 3, "busy_ignore");
    @(posedge clk); #1;
    chk("busy_ignore_idle", {30'd0, busy, done}, 32'd0);

    // back-to-back: second start given in the done cycle
    launch(32'hA5A5_0000, 6'd16, 1'b1, 1'b0);
    finish(32'hFFFF_A5A5, 2, 0, "b2b_first");
    launch(32'h0000_00F0, 6'd4, 1'b0, 1'b1);
    finish(32'h0000_000F, 5, 0, "b2b_second");

    // reset in the middle of a long shift
    launch(32'h8000_0000, 6'd31, 1'b1, 1'b0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done) saw_done = 1'b1;
      end
      rstb = 1'b0;
      @(posedge clk); #1;
      chk("midrst_z", Z, 32'h0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      rstb = 1'b1;
      repeat (20) begin
        @(posedge clk); #1;
        if (done || busy) saw_done = 1'b1;
      end
      chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
    end
    prev_z = 32'h0;
    launch(32'h8765_4321, 6'd20, 1'b1, 1'b0);
    finish(32'hFFFF_F876, 6, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
